// File: rtl/blit_pkg.sv
// Shared widths and types for the blitter memory ports.
package blit_pkg;

    localparam int BLIT_ADDR_W = 26;
    localparam int BLIT_DATA_W = 32;

    typedef logic [BLIT_ADDR_W-1:0] blit_addr_t;
    typedef logic [BLIT_DATA_W-1:0] blit_data_t;

endpackage

// File: rtl/blit_sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra bit to tell full from empty.
module blit_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/blit_read_fifo.sv
// Blitter read port: queues p2 read addresses, issues them to SDRAM under a data-buffer
// credit limit, and returns the read words to p4 in request order.
module blit_read_fifo
    import blit_pkg::*;
#(
    parameter int REQ_DEPTH   = 16,
    parameter int DATA_DEPTH  = 16,
    parameter int FULL_MARGIN = 4
) (
    input  logic       clock,
    input  logic       reset,
    output logic       read_fifo_full,
    input  logic       p2_read,
    input  blit_addr_t p2_address,
    output logic       p4_rvalid,
    output blit_data_t p4_rdata,
    input  logic       p4_ready,
    output logic       blitr_sdram_request,
    input  logic       blitr_sdram_ready,
    output blit_addr_t blitr_sdram_address,
    input  logic       blitr_sdram_rvalid,
    input  blit_data_t blitr_sdram_rdata,
    output logic       fault_detected
);
    localparam int RW = $clog2(REQ_DEPTH) + 1;
    localparam int CW = $clog2(DATA_DEPTH) + 1;

    localparam logic [RW-1:0] REQ_DEPTH_C   = RW'(REQ_DEPTH);
    localparam logic [RW-1:0] FULL_MARGIN_C = RW'(FULL_MARGIN);
    localparam logic [CW-1:0] DATA_DEPTH_C  = CW'(DATA_DEPTH);
    localparam logic [CW-1:0] CNT_ONE       = 1;

    logic [RW-1:0] req_count;
    logic          req_full;
    logic          req_empty;
    logic [CW-1:0] data_count;
    logic          data_full;
    logic          data_empty;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] credit;
    logic          accept;
    logic          rvalid_ok;
    logic          data_push;
    logic          data_pop;
    logic          overflow_fault;
    logic          spurious_fault;

    blit_sync_fifo #(.WIDTH(BLIT_ADDR_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clock (clock),
        .reset (reset),
        .push  (p2_read),
        .pop   (accept),
        .wdata (p2_address),
        .rdata (blitr_sdram_address),
        .count (req_count),
        .full  (req_full),
        .empty (req_empty)
    );

    blit_sync_fifo #(.WIDTH(BLIT_DATA_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clock (clock),
        .reset (reset),
        .push  (data_push),
        .pop   (data_pop),
        .wdata (blitr_sdram_rdata),
        .rdata (p4_rdata),
        .count (data_count),
        .full  (data_full),
        .empty (data_empty)
    );

    // Every issued read owns a data slot until p4 consumes it, so the buffer never overflows.
    assign credit              = DATA_DEPTH_C - data_count - outstanding;
    assign blitr_sdram_request = !req_empty && (credit != '0);
    assign accept              = blitr_sdram_request && blitr_sdram_ready;

    assign p4_rvalid = !data_empty;
    assign data_pop  = p4_rvalid && p4_ready;

    assign rvalid_ok = blitr_sdram_rvalid && (outstanding != '0);
    assign data_push = rvalid_ok && (!data_full || data_pop);

    assign overflow_fault = p2_read && req_full && !accept;
    assign spurious_fault = blitr_sdram_rvalid && (outstanding == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding    <= '0;
            read_fifo_full <= 1'b0;
            fault_detected <= 1'b0;
        end else begin
            case ({accept, rvalid_ok})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase
            read_fifo_full <= (REQ_DEPTH_C - req_count) < FULL_MARGIN_C;
            fault_detected <= overflow_fault || spurious_fault;
        end
    end

endmodule

// File: tb/tb_blit_read_fifo.sv
// Directed and randomized checks of blit_read_fifo with an in-order SDRAM responder model.
module tb_blit_read_fifo;
    import blit_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       p2_read = 1'b0;
    blit_addr_t p2_address = '0;
    logic       p4_ready = 1'b0;
    logic       sdram_ready = 1'b0;
    logic       man_rvalid = 1'b0;
    blit_data_t man_rdata = '0;
    logic       mem_en = 1'b0;
    logic       mem_rvalid = 1'b0;
    blit_data_t mem_rdata = '0;

    logic       read_fifo_full;
    logic       p4_rvalid;
    blit_data_t p4_rdata;
    logic       sdram_request;
    blit_addr_t sdram_address;
    logic       sdram_rvalid;
    blit_data_t sdram_rdata;
    logic       fault_detected;

    assign sdram_rvalid = mem_en ? mem_rvalid : man_rvalid;
    assign sdram_rdata  = mem_en ? mem_rdata  : man_rdata;

    always #5 clock = ~clock;

    blit_read_fifo dut (
        .clock               (clock),
        .reset               (reset),
        .read_fifo_full      (read_fifo_full),
        .p2_read             (p2_read),
        .p2_address          (p2_address),
        .p4_rvalid           (p4_rvalid),
        .p4_rdata            (p4_rdata),
        .p4_ready            (p4_ready),
        .blitr_sdram_request (sdram_request),
        .blitr_sdram_ready   (sdram_ready),
        .blitr_sdram_address (sdram_address),
        .blitr_sdram_rvalid  (sdram_rvalid),
        .blitr_sdram_rdata   (sdram_rdata),
        .fault_detected      (fault_detected)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    typedef struct {
        logic rd;
        logic exp_req;
        logic exp_full;
        logic exp_fault;
    } vec_t;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    rd_t         rq[$];
    logic [31:0] sb[$];
    int          out_m, dcount_m, last_due, acc_cnt, viol;
    int          lat_min = 1, lat_max = 1;
    int          issued;
    vec_t        tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: returns sdram_address^KEY in order, latency lat_min..lat_max after accept.
    task automatic mem_tick();
        logic rv, acc, pop;
        int   credit_m, due;
        rv = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            rv = 1'b1;
            mem_rdata = rq[0].data;
            void'(rq.pop_front());
        end
        mem_rvalid = rv;
        if (p2_read) sb.push_back({6'b0, p2_address} ^ KEY);
        credit_m = 16 - dcount_m - out_m;
        if (sdram_request && credit_m <= 0) viol++;
        if (out_m > 16) viol++;
        if (fault_detected) viol++;
        acc = sdram_request && sdram_ready;
        if (acc) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rq.push_back('{due, {6'b0, sdram_address} ^ KEY});
            acc_cnt++;
        end
        pop = p4_rvalid && p4_ready;
        if (pop) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL p4 pop: got %0h expected no data", p4_rdata);
            end else begin
                chk("p4 data order", p4_rdata, sb[0]);
                void'(sb.pop_front());
            end
        end
        out_m    += int'(acc) - int'(rv);
        dcount_m += int'(rv) - int'(pop);
    endtask

    task automatic next_cycle();
        @(negedge clock);
        if (mem_en) mem_tick();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        p2_read = 1'b0;
        p4_ready = 1'b0;
        sdram_ready = 1'b0;
        man_rvalid = 1'b0;
        mem_en = 1'b0;
        rq.delete();
        sb.delete();
        out_m = 0; dcount_m = 0; last_due = 0; acc_cnt = 0; viol = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 18; k++) begin
            tbl[k].rd        = (k <= 16);
            tbl[k].exp_req   = (k >= 1);
            tbl[k].exp_full  = (k >= 14);
            tbl[k].exp_fault = (k == 17);
        end

        // Reset state and single read
        do_reset();
        #1;
        chk("reset request", sdram_request, 1'b0);
        chk("reset p4_rvalid", p4_rvalid, 1'b0);
        chk("reset full", read_fifo_full, 1'b0);
        chk("reset fault", fault_detected, 1'b0);
        next_cycle(); p2_read = 1'b1; p2_address = 26'h40; sdram_ready = 1'b1; #1;
        chk("t1 request c0", sdram_request, 1'b0);
        next_cycle(); p2_read = 1'b0; #1;
        chk("t1 request c1", sdram_request, 1'b1);
        chk("t1 address", sdram_address, 26'h40);
        next_cycle(); #1;
        chk("t1 request c2", sdram_request, 1'b0);
        next_cycle();
        next_cycle(); man_rvalid = 1'b1; man_rdata = 32'hDEADBEEF; #1;
        chk("t1 p4_rvalid c4", p4_rvalid, 1'b0);
        next_cycle(); man_rvalid = 1'b0; p4_ready = 1'b1; #1;
        chk("t1 p4_rvalid c5", p4_rvalid, 1'b1);
        chk("t1 p4_rdata", p4_rdata, 32'hDEADBEEF);
        next_cycle(); p4_ready = 1'b0; #1;
        chk("t1 p4_rvalid c6", p4_rvalid, 1'b0);
        chk("t1 fault", fault_detected, 1'b0);

        // Spurious rvalid
        next_cycle(); man_rvalid = 1'b1; man_rdata = 32'h1234; #1;
        next_cycle(); man_rvalid = 1'b0; #1;
        chk("t5 fault pulse", fault_detected, 1'b1);
        chk("t5 p4_rvalid", p4_rvalid, 1'b0);
        next_cycle(); #1;
        chk("t5 fault clear", fault_detected, 1'b0);
        chk("t5 p4_rvalid after", p4_rvalid, 1'b0);

        // Fill with ready=0: full flag timing and overflow fault
        do_reset();
        for (int k = 0; k < 18; k++) begin
            next_cycle();
            p2_read = tbl[k].rd;
            p2_address = 26'(32'h200 + 4 * k);
            sdram_ready = 1'b0;
            #1;
            chk($sformatf("t3 request c%0d", k), sdram_request, tbl[k].exp_req);
            chk($sformatf("t3 full c%0d", k), read_fifo_full, tbl[k].exp_full);
            chk($sformatf("t3 fault c%0d", k), fault_detected, tbl[k].exp_fault);
        end
        for (int d = 0; d <= 16; d++) begin
            next_cycle();
            p2_read = 1'b0; sdram_ready = 1'b1; p4_ready = 1'b1;
            man_rvalid = (d >= 1); man_rdata = 32'(d);
            #1;
            chk($sformatf("t3 drain request d%0d", d), sdram_request, (d < 16));
            if (d < 16) chk($sformatf("t3 drain address d%0d", d), sdram_address, 26'(32'h200 + 4 * d));
            chk($sformatf("t3 drain fault d%0d", d), fault_detected, 1'b0);
            chk($sformatf("t3 drain p4_rvalid d%0d", d), p4_rvalid, (d >= 2));
            if (d >= 2) chk($sformatf("t3 drain p4_rdata d%0d", d), p4_rdata, 32'(d - 1));
        end
        next_cycle(); man_rvalid = 1'b0; sdram_ready = 1'b0; #1;
        chk("t3 last word", p4_rdata, 32'd16);
        chk("t3 last fault", fault_detected, 1'b0);
        next_cycle(); p4_ready = 1'b0; #1;
        chk("t3 drained p4_rvalid", p4_rvalid, 1'b0);

        // Reset with 5 queued and 3 outstanding
        do_reset();
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            p2_read = 1'b1; p2_address = 26'(32'h1000 + 4 * k);
            sdram_ready = (k >= 1 && k <= 3);
        end
        next_cycle(); p2_read = 1'b0; sdram_ready = 1'b0; reset = 1'b1; #1;
        chk("t6 request before reset", sdram_request, 1'b1);
        next_cycle(); reset = 1'b0; p2_read = 1'b1; p2_address = 26'h3000; sdram_ready = 1'b1; #1;
        chk("t6 request after reset", sdram_request, 1'b0);
        chk("t6 p4_rvalid after reset", p4_rvalid, 1'b0);
        chk("t6 full after reset", read_fifo_full, 1'b0);
        next_cycle(); p2_read = 1'b0; #1;
        chk("t6 new request", sdram_request, 1'b1);
        chk("t6 new address", sdram_address, 26'h3000);
        next_cycle(); man_rvalid = 1'b1; man_rdata = 32'hCAFEF00D; #1;
        chk("t6 queue empty", sdram_request, 1'b0);
        next_cycle(); man_rvalid = 1'b0; p4_ready = 1'b1; #1;
        chk("t6 p4_rvalid", p4_rvalid, 1'b1);
        chk("t6 p4_rdata", p4_rdata, 32'hCAFEF00D);
        chk("t6 fault", fault_detected, 1'b0);
        next_cycle(); p4_ready = 1'b0; #1;
        chk("t6 p4_rvalid end", p4_rvalid, 1'b0);

        // Burst of 16 with p4 stalled: credit limits issue
        do_reset();
        mem_en = 1'b1; lat_min = 2; lat_max = 2;
        for (int k = 0; k < 16; k++) begin
            next_cycle();
            p2_read = 1'b1; p2_address = 26'(32'h100 + 4 * k);
            sdram_ready = 1'b1; p4_ready = 1'b0;
        end
        next_cycle(); p2_read = 1'b0;
        repeat (25) next_cycle();
        chk("t2 accepts", 32'(acc_cnt), 32'd16);
        chk("t2 request credit 0", sdram_request, 1'b0);
        chk("t2 p4_rvalid", p4_rvalid, 1'b1);
        next_cycle(); p2_read = 1'b1; p2_address = 26'h140;
        next_cycle(); p2_read = 1'b0;
        repeat (3) next_cycle();
        chk("t2 request held by credit", sdram_request, 1'b0);
        chk("t2 accepts held", 32'(acc_cnt), 32'd16);
        p4_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) next_cycle();
        chk("t2 drain complete", 32'(sb.size()), 32'd0);
        chk("t2 final accepts", 32'(acc_cnt), 32'd17);
        chk("t2 violations", 32'(viol), 32'd0);

        // Random traffic
        do_reset();
        mem_en = 1'b1; lat_min = 1; lat_max = 8; issued = 0;
        for (int i = 0; i < 30000 && (issued < 1000 || sb.size() != 0); i++) begin
            next_cycle();
            p2_read = 1'b0;
            if (issued < 1000 && !read_fifo_full && ($urandom % 2) == 1) begin
                p2_read = 1'b1;
                p2_address = 26'($urandom) & ~26'h3;
                issued++;
            end
            sdram_ready = ($urandom % 2) == 1;
            p4_ready = ($urandom % 2) == 1;
        end
        p2_read = 1'b0;
        next_cycle();
        chk("t4 issued", 32'(issued), 32'd1000);
        chk("t4 scoreboard empty", 32'(sb.size()), 32'd0);
        chk("t4 violations", 32'(viol), 32'd0);
        chk("t4 outstanding", 32'(out_m), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
